// File: rtl/calc_op_sequencer_pkg.sv
// Shared opcode encodings, FSM state encodings and display limits for the
// calculator operation sequencer.
package calc_op_sequencer_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_REM = 3'b100;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_COMMIT = 2'd3;

   localparam int unsigned MAX_MAG_DEFAULT = 999;

   // Every opcode with the top bit set is a remainder.
   function automatic logic is_rem(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/calc_op_sequencer_btn_debounce.sv
// Centre-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse on the rising edge of the debounced level.
module calc_op_sequencer_btn_debounce #(
   parameter int unsigned DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press_o
);

   localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          stable_q;
   logic          stable_prev_q;
   logic [CW-1:0] cnt_q;

   // The counter only runs while the synchronised input disagrees with the
   // accepted level; any agreement restarts the stability window.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         sync1_q       <= btn_raw;
         sync2_q       <= sync1_q;
         stable_prev_q <= stable_q;
         if (sync2_q != stable_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
               stable_q <= sync2_q;
               cnt_q    <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign press_o = stable_q & ~stable_prev_q;

endmodule

// File: rtl/calc_op_sequencer.sv
// One calculator operation per debounced press: latch operands, strobe the
// shared ALU, wait for done (or time out), commit to display/accumulator.
module calc_op_sequencer
   import calc_op_sequencer_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 1_000_000,
   parameter int unsigned TIMEOUT    = 64,
   parameter int unsigned MAX_MAG    = MAX_MAG_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_raw,
   input  logic        chain_en,
   input  logic [2:0]  op_sel,
   input  logic [4:0]  a_mag,
   input  logic        a_neg,
   input  logic [4:0]  b_mag,
   input  logic        b_neg,
   output logic        alu_start,
   output logic [2:0]  alu_op,
   output logic [15:0] alu_a,
   output logic        alu_a_neg,
   output logic [15:0] alu_b,
   output logic        alu_b_neg,
   input  logic        alu_done,
   input  logic [15:0] alu_result,
   input  logic        alu_neg,
   input  logic        alu_err,
   output logic [15:0] disp_value,
   output logic        disp_neg,
   output logic        disp_err,
   output logic        busy
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic          press;
   logic          chain_rise;

   logic [1:0]    state_q,      state_d;
   logic [2:0]    alu_op_q,     alu_op_d;
   logic [15:0]   alu_a_q,      alu_a_d;
   logic          alu_a_neg_q,  alu_a_neg_d;
   logic [15:0]   alu_b_q,      alu_b_d;
   logic          alu_b_neg_q,  alu_b_neg_d;
   logic [TW-1:0] tmo_q,        tmo_d;
   logic [15:0]   res_mag_q,    res_mag_d;
   logic          res_neg_q,    res_neg_d;
   logic          res_err_q,    res_err_d;
   logic [15:0]   disp_value_q, disp_value_d;
   logic          disp_neg_q,   disp_neg_d;
   logic          disp_err_q,   disp_err_d;
   logic [15:0]   acc_mag_q,    acc_mag_d;
   logic          acc_neg_q,    acc_neg_d;
   logic          chain_q,      chain_d;
   logic          skip_acc_q,   skip_acc_d;

   calc_op_sequencer_btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_raw),
      .press_o (press)
   );

   assign chain_rise = chain_en & ~chain_q;

   always_comb begin
      state_d      = state_q;
      alu_op_d     = alu_op_q;
      alu_a_d      = alu_a_q;
      alu_a_neg_d  = alu_a_neg_q;
      alu_b_d      = alu_b_q;
      alu_b_neg_d  = alu_b_neg_q;
      tmo_d        = tmo_q;
      res_mag_d    = res_mag_q;
      res_neg_d    = res_neg_q;
      res_err_d    = res_err_q;
      disp_value_d = disp_value_q;
      disp_neg_d   = disp_neg_q;
      disp_err_d   = disp_err_q;
      acc_mag_d    = acc_mag_q;
      acc_neg_d    = acc_neg_q;
      chain_d      = chain_en;
      skip_acc_d   = skip_acc_q;

      case (state_q)
         ST_IDLE: begin
            tmo_d = '0;
            if (press) begin
               state_d     = ST_ISSUE;
               alu_op_d    = op_sel;
               alu_b_d     = {11'b0, b_mag};
               alu_b_neg_d = b_neg;
               // A chain that starts this very cycle begins from a cleared accumulator.
               if (chain_en) begin
                  alu_a_d     = chain_rise ? 16'd0 : acc_mag_q;
                  alu_a_neg_d = chain_rise ? 1'b0  : acc_neg_q;
               end else begin
                  alu_a_d     = {11'b0, a_mag};
                  alu_a_neg_d = a_neg;
               end
            end
         end
         ST_ISSUE, ST_WAIT: begin
            if (alu_done) begin
               state_d   = ST_COMMIT;
               res_mag_d = alu_result;
               res_neg_d = alu_neg & ~is_rem(alu_op_q) & (alu_result != 16'd0);
               res_err_d = alu_err | (alu_result > 16'(MAX_MAG));
            end else if (state_q == ST_ISSUE) begin
               state_d = ST_WAIT;
               tmo_d   = '0;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               state_d   = ST_COMMIT;
               res_err_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            skip_acc_d = 1'b0;
            if (res_err_q) begin
               disp_err_d = 1'b1;
            end else begin
               disp_value_d = res_mag_q;
               disp_neg_d   = res_neg_q;
               disp_err_d   = 1'b0;
               if (chain_en && !skip_acc_q && !chain_rise) begin
                  acc_mag_d = res_mag_q;
                  acc_neg_d = res_neg_q;
               end
            end
         end
      endcase

      if (!chain_en || chain_rise) begin
         acc_mag_d = 16'd0;
         acc_neg_d = 1'b0;
      end
      // An operation already in flight when chaining starts goes to the display only.
      if (chain_rise && state_q != ST_COMMIT) begin
         disp_value_d = 16'd0;
         disp_neg_d   = 1'b0;
         disp_err_d   = 1'b0;
         if (state_q != ST_IDLE) skip_acc_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         alu_op_q     <= 3'd0;
         alu_a_q      <= 16'd0;
         alu_a_neg_q  <= 1'b0;
         alu_b_q      <= 16'd0;
         alu_b_neg_q  <= 1'b0;
         tmo_q        <= '0;
         res_mag_q    <= 16'd0;
         res_neg_q    <= 1'b0;
         res_err_q    <= 1'b0;
         disp_value_q <= 16'd0;
         disp_neg_q   <= 1'b0;
         disp_err_q   <= 1'b0;
         acc_mag_q    <= 16'd0;
         acc_neg_q    <= 1'b0;
         chain_q      <= 1'b0;
         skip_acc_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         alu_op_q     <= alu_op_d;
         alu_a_q      <= alu_a_d;
         alu_a_neg_q  <= alu_a_neg_d;
         alu_b_q      <= alu_b_d;
         alu_b_neg_q  <= alu_b_neg_d;
         tmo_q        <= tmo_d;
         res_mag_q    <= res_mag_d;
         res_neg_q    <= res_neg_d;
         res_err_q    <= res_err_d;
         disp_value_q <= disp_value_d;
         disp_neg_q   <= disp_neg_d;
         disp_err_q   <= disp_err_d;
         acc_mag_q    <= acc_mag_d;
         acc_neg_q    <= acc_neg_d;
         chain_q      <= chain_d;
         skip_acc_q   <= skip_acc_d;
      end
   end

   assign alu_start  = (state_q == ST_ISSUE);
   assign alu_op     = alu_op_q;
   assign alu_a      = alu_a_q;
   assign alu_a_neg  = alu_a_neg_q;
   assign alu_b      = alu_b_q;
   assign alu_b_neg  = alu_b_neg_q;
   assign disp_value = disp_value_q;
   assign disp_neg   = disp_neg_q;
   assign disp_err   = disp_err_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with a small sign-magnitude ALU
// responder that answers one cycle after each start strobe.
module tb_calc_op_sequencer;

   localparam int unsigned DEB_CYCLES = 100;
   localparam int unsigned TIMEOUT    = 300;
   localparam int unsigned MAX_MAG    = 999;

   logic        clk;
   logic        rst;
   logic        btn_raw;
   logic        chain_en;
   logic [2:0]  op_sel;
   logic [4:0]  a_mag;
   logic        a_neg;
   logic [4:0]  b_mag;
   logic        b_neg;
   logic        alu_start;
   logic [2:0]  alu_op;
   logic [15:0] alu_a;
   logic        alu_a_neg;
   logic [15:0] alu_b;
   logic        alu_b_neg;
   logic        alu_done;
   logic [15:0] alu_result;
   logic        alu_neg;
   logic        alu_err;
   logic [15:0] disp_value;
   logic        disp_neg;
   logic        disp_err;
   logic        busy;

   int          checks;
   int          failures;
   int          start_cnt;
   bit          alu_dead;
   logic [2:0]  last_op;
   logic [15:0] last_a;
   logic        last_a_neg;
   logic [15:0] last_b;
   logic        last_b_neg;

   calc_op_sequencer #(
      .DEB_CYCLES (DEB_CYCLES),
      .TIMEOUT    (TIMEOUT),
      .MAX_MAG    (MAX_MAG)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw),
      .chain_en   (chain_en),
      .op_sel     (op_sel),
      .a_mag      (a_mag),
      .a_neg      (a_neg),
      .b_mag      (b_mag),
      .b_neg      (b_neg),
      .alu_start  (alu_start),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_a_neg  (alu_a_neg),
      .alu_b      (alu_b),
      .alu_b_neg  (alu_b_neg),
      .alu_done   (alu_done),
      .alu_result (alu_result),
      .alu_neg    (alu_neg),
      .alu_err    (alu_err),
      .disp_value (disp_value),
      .disp_neg   (disp_neg),
      .disp_err   (disp_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (alu_start) start_cnt++;

   // ALU responder: sign-magnitude semantics, mul/div sign is the XOR of operand signs.
   always @(negedge clk) begin
      if (alu_start) begin
         int sa, sb, r;
         logic rn, re;
         last_op = alu_op; last_a = alu_a; last_a_neg = alu_a_neg;
         last_b = alu_b;   last_b_neg = alu_b_neg;
         sa = alu_a_neg ? -int'(alu_a) : int'(alu_a);
         sb = alu_b_neg ? -int'(alu_b) : int'(alu_b);
         r = 0; re = 1'b0; rn = 1'b0;
         case (alu_op)
            3'b000:  begin r = sa + sb; rn = (r < 0); end
            3'b001:  begin r = sa - sb; rn = (r < 0); end
            3'b010:  begin r = sa * sb; rn = alu_a_neg ^ alu_b_neg; end
            3'b011:  begin if (sb == 0) re = 1'b1; else r = sa / sb; rn = alu_a_neg ^ alu_b_neg; end
            default: begin if (sb == 0) re = 1'b1; else r = sa % sb; rn = (r < 0); end
         endcase
         if (!alu_dead) begin
            @(posedge clk); #1;
            alu_done = 1'b1;
            alu_result = 16'((r < 0) ? -r : r);
            alu_neg = rn;
            alu_err = re;
            @(posedge clk); #1;
            alu_done = 1'b0;
            alu_err = 1'b0;
         end
      end
   end

   task automatic set_op(input logic [2:0] op, input logic [4:0] am, input logic an,
                         input logic [4:0] bm, input logic bn);
      op_sel = op; a_mag = am; a_neg = an; b_mag = bm; b_neg = bn;
   endtask

   // Holds the button until the start strobe appears, then releases and lets it settle.
   task automatic do_press(output bit started);
      int n;
      started = 1'b0;
      n = 0;
      btn_raw = 1'b1;
      while (!started && n < int'(DEB_CYCLES) + 50) begin
         @(negedge clk);
         n++;
         if (alu_start) started = 1'b1;
      end
      btn_raw = 1'b0;
      repeat (DEB_CYCLES + 10) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; btn_raw = 1'b0; chain_en = 1'b0; alu_dead = 1'b0;
      alu_done = 1'b0; alu_result = 16'd0; alu_neg = 1'b0; alu_err = 1'b0;
      set_op(3'b000, 5'd0, 1'b0, 5'd0, 1'b0);
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (alu_start !== 1'b0)  begin failures++; $display("FAIL reset_start got=%0b exp=0", alu_start); end
      checks++; if (disp_value !== 16'd0) begin failures++; $display("FAIL reset_disp got=%0d exp=0", disp_value); end
      checks++; if (disp_err !== 1'b0)   begin failures++; $display("FAIL reset_err got=%0b exp=0", disp_err); end
      checks++; if (alu_a !== 16'd0)     begin failures++; $display("FAIL reset_alu_a got=%0d exp=0", alu_a); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_add;
      bit ok;
      set_op(3'b000, 5'd5, 1'b0, 5'd3, 1'b1);
      do_press(ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL add_start got=%0b exp=1", ok); end
      checks++; if ({last_a, last_a_neg} !== {16'd5, 1'b0}) begin failures++; $display("FAIL add_alu_a got=%0d/%0b exp=5/0", last_a, last_a_neg); end
      checks++; if ({last_b, last_b_neg} !== {16'd3, 1'b1}) begin failures++; $display("FAIL add_alu_b got=%0d/%0b exp=3/1", last_b, last_b_neg); end
      checks++; if ({disp_value, disp_neg, disp_err} !== {16'd2, 1'b0, 1'b0}) begin
         failures++; $display("FAIL add_disp got=%0d/%0b/%0b exp=2/0/0", disp_value, disp_neg, disp_err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL add_busy got=%0b exp=0", busy); end
   endtask

   task automatic test_signs;
      bit ok;
      set_op(3'b001, 5'd5, 1'b0, 5'd9, 1'b0);
      do_press(ok);
      checks++; if ({ok, disp_value, disp_neg} !== {1'b1, 16'd4, 1'b1}) begin
         failures++; $display("FAIL sub_neg got=%0b/%0d/%0b exp=1/4/1", ok, disp_value, disp_neg); end
      set_op(3'b010, 5'd0, 1'b0, 5'd3, 1'b1);
      do_press(ok);
      checks++; if ({ok, disp_value, disp_neg} !== {1'b1, 16'd0, 1'b0}) begin
         failures++; $display("FAIL neg_zero got=%0b/%0d/%0b exp=1/0/0", ok, disp_value, disp_neg); end
      set_op(3'b100, 5'd7, 1'b1, 5'd3, 1'b0);
      do_press(ok);
      checks++; if ({ok, disp_value, disp_neg} !== {1'b1, 16'd1, 1'b0}) begin
         failures++; $display("FAIL rem_sign got=%0b/%0d/%0b exp=1/1/0", ok, disp_value, disp_neg); end
   endtask

   task automatic test_bounce;
      int s0;
      s0 = start_cnt;
      set_op(3'b000, 5'd1, 1'b0, 5'd1, 1'b0);
      btn_raw = 1'b0;
      for (int i = 0; i < 50; i++) begin
         btn_raw = ~btn_raw;
         repeat (10) @(negedge clk);
      end
      checks++; if (start_cnt !== s0) begin failures++; $display("FAIL bounce_filtered got=%0d exp=%0d", start_cnt, s0); end
      btn_raw = 1'b1;
      repeat (DEB_CYCLES + 20) @(negedge clk);
      btn_raw = 1'b0;
      repeat (DEB_CYCLES + 20) @(negedge clk);
      checks++; if (start_cnt !== s0 + 1) begin failures++; $display("FAIL bounce_one_start got=%0d exp=%0d", start_cnt, s0 + 1); end
      checks++; if (disp_value !== 16'd2) begin failures++; $display("FAIL bounce_disp got=%0d exp=2", disp_value); end
   endtask

   task automatic test_chain;
      bit ok;
      logic [15:0] exp_a [3];
      exp_a = '{16'd0, 16'd7, 16'd14};
      chain_en = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (disp_value !== 16'd0) begin failures++; $display("FAIL chain_clear got=%0d exp=0", disp_value); end
      set_op(3'b000, 5'd0, 1'b0, 5'd7, 1'b0);
      for (int i = 0; i < 3; i++) begin
         do_press(ok);
         checks++; if ({ok, last_a} !== {1'b1, exp_a[i]}) begin
            failures++; $display("FAIL chain_alu_a[%0d] got=%0b/%0d exp=1/%0d", i, ok, last_a, exp_a[i]); end
      end
      checks++; if ({disp_value, disp_neg} !== {16'd21, 1'b0}) begin
         failures++; $display("FAIL chain_sum got=%0d/%0b exp=21/0", disp_value, disp_neg); end
      chain_en = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (disp_value !== 16'd21) begin failures++; $display("FAIL chain_off_hold got=%0d exp=21", disp_value); end
      chain_en = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (disp_value !== 16'd0) begin failures++; $display("FAIL chain_reclear got=%0d exp=0", disp_value); end
   endtask

   task automatic test_div_zero;
      bit ok;
      chain_en = 1'b0;
      set_op(3'b000, 5'd9, 1'b0, 5'd4, 1'b0);
      do_press(ok);
      checks++; if ({ok, disp_value} !== {1'b1, 16'd13}) begin failures++; $display("FAIL dz_setup got=%0b/%0d exp=1/13", ok, disp_value); end
      set_op(3'b011, 5'd9, 1'b0, 5'd0, 1'b0);
      do_press(ok);
      checks++; if ({ok, disp_err, disp_value} !== {1'b1, 1'b1, 16'd13}) begin
         failures++; $display("FAIL dz_err got=%0b/%0b/%0d exp=1/1/13", ok, disp_err, disp_value); end
      set_op(3'b000, 5'd2, 1'b0, 5'd1, 1'b0);
      do_press(ok);
      checks++; if ({ok, disp_err, disp_value} !== {1'b1, 1'b0, 16'd3}) begin
         failures++; $display("FAIL dz_recover got=%0b/%0b/%0d exp=1/0/3", ok, disp_err, disp_value); end
   endtask

   task automatic test_overflow;
      bit ok;
      chain_en = 1'b1;
      repeat (2) @(negedge clk);
      set_op(3'b000, 5'd0, 1'b0, 5'd31, 1'b0);
      do_press(ok);
      set_op(3'b010, 5'd0, 1'b0, 5'd31, 1'b0);
      do_press(ok);
      checks++; if ({ok, disp_value, disp_err} !== {1'b1, 16'd961, 1'b0}) begin
         failures++; $display("FAIL ovf_961 got=%0b/%0d/%0b exp=1/961/0", ok, disp_value, disp_err); end
      set_op(3'b010, 5'd0, 1'b0, 5'd2, 1'b0);
      do_press(ok);
      checks++; if ({ok, disp_value, disp_err} !== {1'b1, 16'd961, 1'b1}) begin
         failures++; $display("FAIL ovf_err got=%0b/%0d/%0b exp=1/961/1", ok, disp_value, disp_err); end
      set_op(3'b000, 5'd0, 1'b0, 5'd1, 1'b0);
      do_press(ok);
      checks++; if ({ok, last_a, disp_value, disp_err} !== {1'b1, 16'd961, 16'd962, 1'b0}) begin
         failures++; $display("FAIL ovf_acc_kept got=%0b/%0d/%0d/%0b exp=1/961/962/0", ok, last_a, disp_value, disp_err); end
   endtask

   task automatic test_timeout;
      int n;
      bit ok;
      chain_en = 1'b0;
      alu_dead = 1'b1;
      set_op(3'b000, 5'd1, 1'b0, 5'd1, 1'b0);
      ok = 1'b0; n = 0; btn_raw = 1'b1;
      while (!ok && n < int'(DEB_CYCLES) + 50) begin
         @(negedge clk); n++;
         if (alu_start) ok = 1'b1;
      end
      btn_raw = 1'b0;
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL tmo_start got=%0b exp=1", ok); end
      n = 0;
      while (disp_err !== 1'b1 && n < int'(TIMEOUT) + 20) begin
         @(negedge clk); n++;
      end
      checks++; if (n != int'(TIMEOUT) + 2) begin failures++; $display("FAIL tmo_latency got=%0d exp=%0d", n, TIMEOUT + 2); end
      checks++; if ({disp_value, busy} !== {16'd962, 1'b0}) begin
         failures++; $display("FAIL tmo_disp got=%0d/%0b exp=962/0", disp_value, busy); end
      repeat (DEB_CYCLES + 10) @(negedge clk);
   endtask

   task automatic test_busy_drop_reset;
      int s0, n;
      bit ok;
      alu_dead = 1'b1;
      s0 = start_cnt;
      ok = 1'b0; n = 0; btn_raw = 1'b1;
      while (!ok && n < int'(DEB_CYCLES) + 50) begin
         @(negedge clk); n++;
         if (alu_start) ok = 1'b1;
      end
      btn_raw = 1'b0;
      repeat (DEB_CYCLES + 10) @(negedge clk);
      btn_raw = 1'b1;
      repeat (DEB_CYCLES + 10) @(negedge clk);
      checks++; if ({start_cnt, busy} !== {s0 + 1, 1'b1}) begin
         failures++; $display("FAIL busy_drop got=%0d/%0b exp=%0d/1", start_cnt, busy, s0 + 1); end
      rst = 1'b1;
      btn_raw = 1'b0;
      @(negedge clk);
      checks++; if ({busy, alu_start, disp_value, disp_err, alu_a} !== {1'b0, 1'b0, 16'd0, 1'b0, 16'd0}) begin
         failures++; $display("FAIL rst_mid_op busy=%0b start=%0b disp=%0d err=%0b a=%0d exp=0/0/0/0/0",
                              busy, alu_start, disp_value, disp_err, alu_a); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (TIMEOUT + 100) @(negedge clk);
      checks++; if ({start_cnt, disp_err, busy} !== {s0 + 1, 1'b0, 1'b0}) begin
         failures++; $display("FAIL rst_no_commit got=%0d/%0b/%0b exp=%0d/0/0", start_cnt, disp_err, busy, s0 + 1); end
      alu_dead = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      start_cnt = 0;
      test_reset();
      test_single_add();
      test_signs();
      test_bounce();
      test_chain();
      test_div_zero();
      test_overflow();
      test_timeout();
      test_busy_drop_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
